// File: rtl/decode_pkg.sv
// Decode-stage shared types: decoded uop bundle and uop queue sizing.
// The uop valid bit doubles as the kill flag once an entry sits in the queue.
package decode_pkg;

  localparam int XLEN          = 32;
  localparam int FETCH_EPOCH_W = 2;

  typedef struct packed {
    logic                     valid;
    logic [XLEN-1:0]          pc;
    logic [31:0]              instr;
    logic [FETCH_EPOCH_W-1:0] fetch_epoch;
  } uop_t;

  localparam int UOPQ_DEPTH = 16;
  localparam int UOPQ_ENQ_W = 4;
  localparam int UOPQ_DEQ_W = 4;
  localparam int UOPQ_CNT_W = $clog2(UOPQ_DEPTH + 1);

  typedef logic [UOPQ_CNT_W-1:0] uopq_cnt_t;

  function automatic logic [6:0] popcnt_lanes(input logic [63:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) begin
      n = n + 7'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/uopq_head_select.sv
// Head window of the uop queue: presents the oldest DEQ_W slots and
// measures the leading run of live entries and of killed entries.
module uopq_head_select
  import decode_pkg::*;
#(
  parameter int DEPTH = UOPQ_DEPTH,
  parameter int DEQ_W = UOPQ_DEQ_W,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int DCW   = $clog2(DEQ_W + 1)
) (
  input  uop_t                       mem_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head_i,
  input  logic [CNT_W-1:0]           count_i,
  output logic [DEQ_W-1:0]           deq_valid_o,
  output uop_t                       deq_uop_o [DEQ_W],
  output logic [DCW-1:0]             lead_valid_o,
  output logic [DCW-1:0]             lead_kill_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0] idx;
  logic             live;
  logic             run_v;
  logic             run_k;

  // A killed slot ends the live run, so valid lanes stay contiguous.
  always_comb begin
    idx          = '0;
    live         = 1'b0;
    run_v        = 1'b1;
    run_k        = 1'b1;
    deq_valid_o  = '0;
    lead_valid_o = '0;
    lead_kill_o  = '0;
    for (int i = 0; i < DEQ_W; i++) begin
      idx          = head_i + IDX_W'(i);
      deq_uop_o[i] = mem_i[idx];
      live         = CNT_W'(i) < count_i;
      run_v        = run_v & live & mem_i[idx].valid;
      run_k        = run_k & live & ~mem_i[idx].valid;
      deq_valid_o[i] = run_v;
      lead_valid_o = lead_valid_o + DCW'(run_v);
      lead_kill_o  = lead_kill_o + DCW'(run_k);
    end
  end

endmodule

// File: rtl/decode_uop_queue.sv
// Multi-lane decoded-uop FIFO between decode and rename/dispatch,
// with full flush and fetch-epoch kill of stale uops.
module decode_uop_queue
  import decode_pkg::*;
#(
  parameter int DEPTH = UOPQ_DEPTH,
  parameter int ENQ_W = UOPQ_ENQ_W,
  parameter int DEQ_W = UOPQ_DEQ_W,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int DCW   = $clog2(DEQ_W + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ENQ_W-1:0]         enq_valid_i,
  input  uop_t                     enq_uop_i [ENQ_W],
  output logic                     enq_ready_o,
  output logic [DEQ_W-1:0]         deq_valid_o,
  output uop_t                     deq_uop_o [DEQ_W],
  input  logic [DCW-1:0]           deq_cnt_i,
  input  logic                     flush_i,
  input  logic [FETCH_EPOCH_W-1:0] flush_epoch_i,
  output logic [CNT_W-1:0]         count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  uop_t                     mem_q [DEPTH];
  logic [PTR_W-1:0]         head_q, head_d;
  logic [PTR_W-1:0]         tail_q, tail_d;
  logic [FETCH_EPOCH_W-1:0] epoch_q, epoch_d;

  logic [CNT_W-1:0]         free;
  logic                     enq_fire;
  logic [CNT_W-1:0]         n_enq;
  logic [CNT_W:0]           pop_raw;
  logic [CNT_W-1:0]         n_pop;
  logic [DCW-1:0]           lead_valid;
  logic [DCW-1:0]           lead_kill;

  uop_t                     wuop [ENQ_W];
  logic [IDX_W-1:0]         widx [ENQ_W];
  logic [ENQ_W-1:0]         wen;

  assign count_o = CNT_W'(tail_q - head_q);
  assign empty_o = head_q == tail_q;
  assign full_o  = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0])
                && (head_q[IDX_W] != tail_q[IDX_W]);

  // Readiness looks only at start-of-cycle occupancy, never at enq_valid_i.
  assign free        = CNT_W'(DEPTH) - count_o;
  assign enq_ready_o = !flush_i && (free >= CNT_W'(ENQ_W));
  assign enq_fire    = enq_ready_o && |enq_valid_i;
  assign n_enq       = enq_fire ? CNT_W'(popcnt_lanes(64'(enq_valid_i))) : '0;

  uopq_head_select #(
    .DEPTH (DEPTH),
    .DEQ_W (DEQ_W),
    .CNT_W (CNT_W),
    .DCW   (DCW)
  ) u_head_select (
    .mem_i        (mem_q),
    .head_i       (head_q[IDX_W-1:0]),
    .count_i      (count_o),
    .deq_valid_o  (deq_valid_o),
    .deq_uop_o    (deq_uop_o),
    .lead_valid_o (lead_valid),
    .lead_kill_o  (lead_kill)
  );

  // Killed entries at the head drain on their own alongside consumed ones.
  assign pop_raw = (CNT_W+1)'(deq_cnt_i) + (CNT_W+1)'(lead_kill);
  assign n_pop   = (pop_raw > {1'b0, count_o}) ? count_o
                                               : pop_raw[CNT_W-1:0];

  always_comb begin
    for (int l = 0; l < ENQ_W; l++) begin
      wuop[l]       = enq_uop_i[l];
      wuop[l].valid = enq_uop_i[l].fetch_epoch == epoch_q;
      widx[l]       = tail_q[IDX_W-1:0] + IDX_W'(l);
      wen[l]        = enq_fire & enq_valid_i[l];
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(n_pop);
    tail_d  = tail_q + PTR_W'(n_enq);
    epoch_d = epoch_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      epoch_d = flush_epoch_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      epoch_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      epoch_q <= epoch_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int l = 0; l < ENQ_W; l++) begin
      if (wen[l]) begin
        mem_q[widx[l]] <= wuop[l];
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ((enq_valid_i & (enq_valid_i + 1'b1)) == '0);
      assert (deq_cnt_i <= DCW'(DEQ_W));
      assert (flush_i || deq_cnt_i <= lead_valid);
      assert (count_o <= CNT_W'(DEPTH));
      assert (flush_i || enq_ready_o || tail_d == tail_q);
    end
  end
`endif

endmodule

// File: tb/tb_decode_uop_queue.sv
// Directed bench for decode_uop_queue: ordering, full/empty, wrap,
// flush, epoch kill and asynchronous reset.
module tb_decode_uop_queue;
  import decode_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [3:0]  enq_valid_i = '0;
  uop_t        enq_uop_i [4];
  logic        enq_ready_o;
  logic [3:0]  deq_valid_o;
  uop_t        deq_uop_o [4];
  logic [2:0]  deq_cnt_i = '0;
  logic        flush_i = 1'b0;
  logic [1:0]  flush_epoch_i = '0;
  logic [4:0]  count_o;
  logic        empty_o;
  logic        full_o;

  int          vecs = 0;
  int          errs = 0;
  logic [31:0] next_pc = 32'h8000_0000;
  logic [31:0] exp_q [$];

  decode_uop_queue dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enq_valid_i   (enq_valid_i),
    .enq_uop_i     (enq_uop_i),
    .enq_ready_o   (enq_ready_o),
    .deq_valid_o   (deq_valid_o),
    .deq_uop_o     (deq_uop_o),
    .deq_cnt_i     (deq_cnt_i),
    .flush_i       (flush_i),
    .flush_epoch_i (flush_epoch_i),
    .count_o       (count_o),
    .empty_o       (empty_o),
    .full_o        (full_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    enq_valid_i = '0;
    deq_cnt_i   = '0;
    flush_i     = 1'b0;
  endtask

  task automatic drive_enq(input int n, input logic [7:0] eps, input bit push);
    enq_valid_i = '0;
    for (int l = 0; l < 4; l++) begin
      enq_uop_i[l] = '0;
      if (l < n) begin
        enq_valid_i[l]           = 1'b1;
        enq_uop_i[l].valid       = 1'b1;
        enq_uop_i[l].pc          = next_pc;
        enq_uop_i[l].instr       = 32'h0000_0013;
        enq_uop_i[l].fetch_epoch = eps[2*l +: 2];
        if (push) exp_q.push_back(next_pc);
        next_pc = next_pc + 32'd4;
      end
    end
  endtask

  task automatic test_reset();
    vecs++;
    if (count_o !== 5'd0) begin
      errs++; $display("FAIL reset_count got %0d want 0", count_o);
    end
    vecs++;
    if ({empty_o, full_o, enq_ready_o} !== 3'b101) begin
      errs++; $display("FAIL reset_flags got %b want 101", {empty_o, full_o, enq_ready_o});
    end
    vecs++;
    if (deq_valid_o !== 4'b0000) begin
      errs++; $display("FAIL reset_deq_valid got %b want 0000", deq_valid_o);
    end
  endtask

  task automatic test_basic();
    logic [31:0] want;
    drive_enq(4, 8'h00, 1'b1);
    tick();
    idle();
    vecs++;
    if (deq_valid_o !== 4'b1111) begin
      errs++; $display("FAIL basic_valid got %b want 1111", deq_valid_o);
    end
    vecs++;
    if (count_o !== 5'd4) begin
      errs++; $display("FAIL basic_count got %0d want 4", count_o);
    end
    for (int i = 0; i < 4; i++) begin
      want = 32'h8000_0000 + 32'(4 * i);
      vecs++;
      if (deq_uop_o[i].pc !== want) begin
        errs++; $display("FAIL basic_pc lane %0d got %h want %h", i, deq_uop_o[i].pc, want);
      end
    end
  endtask

  task automatic test_fill();
    drive_enq(4, 8'h00, 1'b1);
    tick();
    drive_enq(4, 8'h00, 1'b1);
    tick();
    idle();
    vecs++;
    if (count_o !== 5'd12 || enq_ready_o !== 1'b1) begin
      errs++; $display("FAIL fill_12 got cnt %0d rdy %b want 12 1", count_o, enq_ready_o);
    end
    drive_enq(4, 8'h00, 1'b1);
    tick();
    idle();
    vecs++;
    if (count_o !== 5'd16 || full_o !== 1'b1 || enq_ready_o !== 1'b0) begin
      errs++; $display("FAIL fill_16 got cnt %0d full %b rdy %b want 16 1 0",
                       count_o, full_o, enq_ready_o);
    end
    drive_enq(4, 8'h00, 1'b0);
    deq_cnt_i = 3'd4;
    tick();
    idle();
    repeat (4) void'(exp_q.pop_front());
    vecs++;
    if (count_o !== 5'd12 || full_o !== 1'b0) begin
      errs++; $display("FAIL fill_deq got cnt %0d full %b want 12 0", count_o, full_o);
    end
    vecs++;
    if (deq_uop_o[0].pc !== 32'h8000_0010) begin
      errs++; $display("FAIL fill_head got %h want 80000010", deq_uop_o[0].pc);
    end
  endtask

  task automatic test_wrap();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 4; i++) begin
        vecs++;
        if (deq_valid_o[i] !== 1'b1 || deq_uop_o[i].pc !== exp_q[i]) begin
          errs++; $display("FAIL drain_pc lane %0d got %b/%h want 1/%h",
                           i, deq_valid_o[i], deq_uop_o[i].pc, exp_q[i]);
        end
      end
      deq_cnt_i = 3'd4;
      tick();
      idle();
      repeat (4) void'(exp_q.pop_front());
    end
    vecs++;
    if (empty_o !== 1'b1 || count_o !== 5'd0) begin
      errs++; $display("FAIL drain_empty got cnt %0d empty %b want 0 1", count_o, empty_o);
    end
    for (int r = 0; r < 5; r++) begin
      drive_enq(4, 8'h00, 1'b1);
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
        vecs++;
        if (deq_valid_o[i] !== 1'b1 || deq_uop_o[i].pc !== exp_q[i]) begin
          errs++; $display("FAIL wrap_pc round %0d lane %0d got %b/%h want 1/%h",
                           r, i, deq_valid_o[i], deq_uop_o[i].pc, exp_q[i]);
        end
      end
      deq_cnt_i = 3'd3;
      tick();
      idle();
      repeat (3) void'(exp_q.pop_front());
      vecs++;
      if (count_o !== 5'(r + 1)) begin
        errs++; $display("FAIL wrap_count round %0d got %0d want %0d", r, count_o, r + 1);
      end
    end
  endtask

  task automatic test_flush();
    drive_enq(4, 8'h00, 1'b1);
    tick();
    idle();
    vecs++;
    if (count_o !== 5'd9) begin
      errs++; $display("FAIL flush_pre got %0d want 9", count_o);
    end
    drive_enq(4, 8'h00, 1'b0);
    deq_cnt_i     = 3'd2;
    flush_i       = 1'b1;
    flush_epoch_i = 2'd3;
    #1;
    vecs++;
    if (enq_ready_o !== 1'b0) begin
      errs++; $display("FAIL flush_ready got %b want 0", enq_ready_o);
    end
    tick();
    idle();
    exp_q.delete();
    vecs++;
    if (count_o !== 5'd0 || empty_o !== 1'b1) begin
      errs++; $display("FAIL flush_clear got cnt %0d empty %b want 0 1", count_o, empty_o);
    end
    drive_enq(4, 8'b10_10_10_10, 1'b0);
    tick();
    idle();
    vecs++;
    if (count_o !== 5'd4 || deq_valid_o !== 4'b0000) begin
      errs++; $display("FAIL stale_enq got cnt %0d valid %b want 4 0000", count_o, deq_valid_o);
    end
    tick();
    vecs++;
    if (count_o !== 5'd0 || empty_o !== 1'b1) begin
      errs++; $display("FAIL stale_pop got cnt %0d empty %b want 0 1", count_o, empty_o);
    end
  endtask

  task automatic test_mixed_epoch();
    logic [31:0] base;
    base = next_pc;
    drive_enq(4, 8'b11_10_11_11, 1'b0);
    tick();
    idle();
    vecs++;
    if (deq_valid_o !== 4'b0011 || count_o !== 5'd4) begin
      errs++; $display("FAIL mixed_first got valid %b cnt %0d want 0011 4", deq_valid_o, count_o);
    end
    vecs++;
    if (deq_uop_o[0].pc !== base || deq_uop_o[1].pc !== base + 32'd4) begin
      errs++; $display("FAIL mixed_pc01 got %h %h want %h %h",
                       deq_uop_o[0].pc, deq_uop_o[1].pc, base, base + 32'd4);
    end
    deq_cnt_i = 3'd2;
    tick();
    idle();
    vecs++;
    if (deq_valid_o !== 4'b0000 || count_o !== 5'd2) begin
      errs++; $display("FAIL mixed_kill got valid %b cnt %0d want 0000 2", deq_valid_o, count_o);
    end
    tick();
    vecs++;
    if (deq_valid_o !== 4'b0001 || count_o !== 5'd1 || deq_uop_o[0].pc !== base + 32'd12) begin
      errs++; $display("FAIL mixed_pc3 got valid %b cnt %0d pc %h want 0001 1 %h",
                       deq_valid_o, count_o, deq_uop_o[0].pc, base + 32'd12);
    end
    deq_cnt_i = 3'd1;
    tick();
    idle();
    vecs++;
    if (empty_o !== 1'b1) begin
      errs++; $display("FAIL mixed_empty got %b want 1", empty_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] first;
    drive_enq(4, 8'hFF, 1'b0);
    tick();
    drive_enq(3, 8'hFF, 1'b0);
    tick();
    idle();
    vecs++;
    if (count_o !== 5'd7) begin
      errs++; $display("FAIL rstmid_pre got %0d want 7", count_o);
    end
    drive_enq(4, 8'hFF, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    vecs++;
    if (count_o !== 5'd0 || {empty_o, full_o, enq_ready_o} !== 3'b101
        || deq_valid_o !== 4'b0000) begin
      errs++; $display("FAIL rstmid_async got cnt %0d flags %b valid %b want 0 101 0000",
                       count_o, {empty_o, full_o, enq_ready_o}, deq_valid_o);
    end
    tick();
    idle();
    rst_i = 1'b0;
    first = next_pc;
    drive_enq(1, 8'h00, 1'b0);
    tick();
    idle();
    vecs++;
    if (deq_valid_o !== 4'b0001 || deq_uop_o[0].pc !== first || count_o !== 5'd1) begin
      errs++; $display("FAIL rstmid_first got valid %b pc %h cnt %0d want 0001 %h 1",
                       deq_valid_o, deq_uop_o[0].pc, count_o, first);
    end
  endtask

  initial begin
    for (int l = 0; l < 4; l++) enq_uop_i[l] = '0;
    tick();
    tick();
    test_reset();
    rst_i = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_fill();
    test_wrap();
    test_flush();
    test_mixed_epoch();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
